// File: rtl/jpeg_stream_packer_if.sv
// jpeg_stream_packer_if: encoder-side input and byte-stream output bundle for jpeg_stream_packer
interface jpeg_stream_packer_if #(parameter int OUT_BYTES = 4);
  logic [31:0]            in_bits;
  logic                   in_rdy;
  logic [4:0]             in_eof_cnt;
  logic                   in_eof_p;
  logic                   in_stall;
  logic [8*OUT_BYTES-1:0] out_data;
  logic [OUT_BYTES-1:0]   out_keep;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   overflow;
  modport master (
    output in_bits, in_rdy, in_eof_cnt, in_eof_p, out_ready,
    input  in_stall, out_data, out_keep, out_valid, out_last, overflow
  );
  modport slave (
    input  in_bits, in_rdy, in_eof_cnt, in_eof_p, out_ready,
    output in_stall, out_data, out_keep, out_valid, out_last, overflow
  );
endinterface

// File: rtl/jpeg_stream_packer.sv
// jpeg_stream_packer: byte-stuffs encoder words into a byte FIFO and emits keep/last beats; JPEG_STREAM_PACKER_EOI_EN appends the FF D9 marker
module jpeg_stream_packer #(
  parameter int OUT_BYTES  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  jpeg_stream_packer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] OB    = PW'(OUT_BYTES);
  localparam logic [PW-1:0] DEPTH = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    STREAM = 2'd0,
`ifdef JPEG_STREAM_PACKER_EOI_EN
    EOI    = 2'd1,
`endif
    FLUSH  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0] count, free, nb;
  logic          ovf_q, ovf_d, empty, pop, wen;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    grp [8];
  logic [7:0]    wb [8];
  logic [3:0]    glen, wl;
  logic [31:0]   word;
  logic [2:0]    nin;

  assign count        = wr_q - rd_q;
  assign free         = DEPTH - count;
  assign empty        = wr_q == rd_q;
  assign bus.in_stall = free < PW'(8);
  assign bus.overflow = ovf_q;
  assign pop          = bus.out_valid & bus.out_ready;
  assign wr_d         = wen ? wr_q + PW'(wl) : wr_q;
  assign rd_d         = pop ? rd_q + nb : rd_q;

  // build the stuffed byte group for a full word or a 1s-padded final partial word
  always_comb begin
    word = bus.in_eof_p ? bus.in_bits | (32'hFFFF_FFFF >> bus.in_eof_cnt) : bus.in_bits;
    nin  = bus.in_eof_p ? 3'((6'(bus.in_eof_cnt) + 6'd7) >> 3) : 3'd4;
    glen = '0;
    for (int k = 0; k < 8; k++) grp[k] = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nin) begin
        grp[glen[2:0]] = word[31-8*i -: 8];
        glen = glen + 4'd1;
        if (word[31-8*i -: 8] == 8'hFF) begin
          grp[glen[2:0]] = 8'h00;
          glen = glen + 4'd1;
        end
      end
    end
  end

  // decide what gets written this cycle; anything that cannot be taken whole is dropped and flagged
  always_comb begin
    wb    = grp;
    wl    = glen;
    wen   = 1'b0;
    ovf_d = ovf_q;
    case (state_q)
      STREAM: begin
        if (bus.in_eof_p && bus.in_rdy) ovf_d = 1'b1;
        if (bus.in_eof_p || bus.in_rdy) begin
          wen   = PW'(glen) <= free;
          ovf_d = ovf_d | ~wen;
        end
      end
`ifdef JPEG_STREAM_PACKER_EOI_EN
      EOI: begin
        wb[0] = 8'hFF;
        wb[1] = 8'hD9;
        wl    = 4'd2;
        wen   = free >= PW'(2);
        ovf_d = ovf_q | bus.in_rdy | bus.in_eof_p;
      end
`endif
      default: ovf_d = ovf_q | bus.in_rdy | bus.in_eof_p;
    endcase
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // byte storage; a whole group lands in one cycle
  always_ff @(posedge clk) begin
    if (wen)
      for (int k = 0; k < 8; k++)
        if (4'(k) < wl) mem_q[wr_q[AW-1:0] + AW'(k)] <= wb[k];
  end

  // frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= STREAM;
    else      state_q <= state_d;
  end

  // frame sequencing; an empty FLUSH has no last beat to wait for
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef JPEG_STREAM_PACKER_EOI_EN
      STREAM: if (bus.in_eof_p) state_d = EOI;
      EOI:    if (free >= PW'(2)) state_d = FLUSH;
`else
      STREAM: if (bus.in_eof_p) state_d = FLUSH;
`endif
      FLUSH:  if ((bus.out_last && bus.out_ready) || empty) state_d = STREAM;
      default: state_d = STREAM;
    endcase
  end

  // output beat from registered count/state; data and keep are zero outside valid beats
  always_comb begin
    nb            = count >= OB ? OB : count;
    bus.out_valid = count >= OB || (state_q == FLUSH && !empty);
    bus.out_last  = state_q == FLUSH && !empty && count <= OB;
    bus.out_data  = '0;
    bus.out_keep  = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      if (bus.out_valid && PW'(j) < nb) begin
        bus.out_data[8*(OUT_BYTES-1-j) +: 8] = mem_q[rd_q[AW-1:0] + AW'(j)];
        bus.out_keep[OUT_BYTES-1-j]          = 1'b1;
      end
    end
  end
endmodule
